// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel counters, registered sync/active decode, sync delay line.
// Optional completed-frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int unsigned H_VIEW      = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VIEW      = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          H_SYNC_POL  = 1'b0,
    parameter bit          V_SYNC_POL  = 1'b0,
    parameter int unsigned SYNC_DELAY  = 2,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ena,
    output logic [9:0]             x_px,
    output logic [9:0]             y_px,
    output logic                   activevideo,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hsync_dly,
    output logic                   vsync_dly,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIEW_W = 11'(H_VIEW);
    localparam logic [10:0] V_VIEW_W = 11'(V_VIEW);
    localparam logic [10:0] HS_BEG = 11'(H_VIEW + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VIEW + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_BEG = 11'(V_VIEW + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VIEW + V_FRONT + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024) begin : g_h_total_chk
            $error("vga_sync_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_chk
            $error("vga_sync_gen: V_TOTAL exceeds 1024");
        end
        if (SYNC_DELAY > 7) begin : g_delay_chk
            $error("vga_sync_gen: SYNC_DELAY must be 0..7");
        end
    endgenerate

    logic       line_end;
    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        line_end = (x_px == H_LAST);
        x_next   = line_end ? '0 : x_px + 10'd1;
        y_next   = y_px;
        if (line_end) begin
            y_next = (y_px == V_LAST) ? '0 : y_px + 10'd1;
        end
    end

    // Decode from the next counter values so the registered flags describe x_px/y_px exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_px        <= '0;
            y_px        <= '0;
            activevideo <= 1'b1;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
        end else if (ena) begin
            x_px        <= x_next;
            y_px        <= y_next;
            activevideo <= ({1'b0, x_next} < H_VIEW_W) && ({1'b0, y_next} < V_VIEW_W);
            hsync       <= (({1'b0, x_next} >= HS_BEG) && ({1'b0, x_next} <= HS_END))
                           ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= (({1'b0, y_next} >= VS_BEG) && ({1'b0, y_next} <= VS_END))
                           ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign hsync_dly = hsync;
            assign vsync_dly = vsync;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_pipe;
            logic [SYNC_DELAY-1:0] vs_pipe;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe <= {SYNC_DELAY{~H_SYNC_POL}};
                    vs_pipe <= {SYNC_DELAY{~V_SYNC_POL}};
                end else if (ena) begin
                    hs_pipe[0] <= hsync;
                    vs_pipe[0] <= vsync;
                    for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign hsync_dly = hs_pipe[SYNC_DELAY-1];
            assign vsync_dly = vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

    // Downstream uses this as a sampling enable, so it must drop during reset
    assign frame_start = reset_n && ena && (x_px == '0) && (y_px == '0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic frame_end;
    assign frame_end = line_end && (y_px == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (ena && frame_end) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized-enable bench for vga_sync_gen on a shrunken raster, checked against an
// arithmetic model derived from the count of enabled cycles since reset.
module tb_vga_sync_gen;

    localparam int HV = 10, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8, VF = 1, VS = 2, VB = 1;
    localparam int HPOL = 0, VPOL = 1;
    localparam int SD = 2;
    localparam int FW = 8;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ena = 1'b0;
    logic [9:0]    x_px, y_px;
    logic          activevideo, hsync, vsync, hsync_dly, vsync_dly, frame_start;
    logic [FW-1:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;   // enabled edges since reset release

    vga_sync_gen #(
        .H_VIEW(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VIEW(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1),
        .SYNC_DELAY(SD), .FRAME_CNT_W(FW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena),
        .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
        .hsync(hsync), .vsync(vsync), .hsync_dly(hsync_dly), .vsync_dly(vsync_dly),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int sync_lvl(input int pos, input int beg, input int len, input int pol);
        return (pos >= beg && pos < beg + len) ? pol : 1 - pol;
    endfunction

    task automatic check_state();
        int x, y, td, exp_fc;
        x  = t % HT;
        y  = (t / HT) % VT;
        td = t - SD;
        check_val("x_px", int'(x_px), x);
        check_val("y_px", int'(y_px), y);
        check_val("activevideo", int'(activevideo), (x < HV && y < VV) ? 1 : 0);
        check_val("hsync", int'(hsync), sync_lvl(x, HV + HF, HS, HPOL));
        check_val("vsync", int'(vsync), sync_lvl(y, VV + VF, VS, VPOL));
        check_val("hsync_dly", int'(hsync_dly),
                  (td < 0) ? 1 - HPOL : sync_lvl(td % HT, HV + HF, HS, HPOL));
        check_val("vsync_dly", int'(vsync_dly),
                  (td < 0) ? 1 - VPOL : sync_lvl((td / HT) % VT, VV + VF, VS, VPOL));
        check_val("frame_start", int'(frame_start), (x == 0 && y == 0 && ena) ? 1 : 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        exp_fc = (t / FRAME) % (1 << FW);
`else
        exp_fc = 0;
`endif
        check_val("frame_cnt", int'(frame_cnt), exp_fc);
    endtask

    task automatic check_reset();
        check_val("rst_x_px", int'(x_px), 0);
        check_val("rst_y_px", int'(y_px), 0);
        check_val("rst_activevideo", int'(activevideo), 1);
        check_val("rst_hsync", int'(hsync), 1 - HPOL);
        check_val("rst_vsync", int'(vsync), 1 - VPOL);
        check_val("rst_hsync_dly", int'(hsync_dly), 1 - HPOL);
        check_val("rst_vsync_dly", int'(vsync_dly), 1 - VPOL);
        check_val("rst_frame_start", int'(frame_start), 0);
        check_val("rst_frame_cnt", int'(frame_cnt), 0);
    endtask

    // Called at a negedge: pick ena, check the current state, then take one edge.
    task automatic step(input bit rnd);
        ena = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        check_state();
        @(posedge clk);
        if (ena) t++;
        @(negedge clk);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        ena = 1'b1;
        #1 check_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        reset_n = 1'b1;
        t = 0;

        for (int i = 0; i < 8000; i++) step(1'b1);

        // Reset asserted between clock edges must take effect immediately
        @(posedge clk);
        #2 reset_n = 1'b0;
        t = 0;
        #1 check_reset();
        @(negedge clk);
        check_reset();
        reset_n = 1'b1;

        while (t < 257 * FRAME + 5) step(1'b0);
        for (int i = 0; i < 500; i++) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
